// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs decoded MIPS fields into 32-bit words and streams
// them with byte addresses through a 2-entry elastic buffer.
module mips_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_class,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [5:0]  in_funct,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        full,
   output logic        illegal,
   output logic [7:0]  illegal_count
);
   logic [1:0]  cnt_q, cnt_d, slot;
   logic [31:0] e0_q, e0_d, e1_q, e1_d, addr_q, addr_d, acc_q, acc_d, emit_q, emit_d;
   logic        full_q, full_d, ill_q, ill_d, rdy_q, rdy_d;
   logic [7:0]  icnt_q, icnt_d;
   logic [5:0]  op;
   logic        legal, take, push, pop;
   logic [31:0] word;

   always_comb begin
      op    = 6'b000000;
      legal = 1'b1;
      case (in_class)
         4'd0: legal = in_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
         4'd1: op = 6'b100011;
         4'd2: op = 6'b101011;
         4'd3: op = 6'b000100;
         4'd4: op = 6'b001000;
         4'd5: op = 6'b001100;
         4'd6: op = 6'b001101;
         4'd7: op = 6'b001110;
         4'd8: op = 6'b001010;
         4'd9: op = 6'b000010;
         default: legal = 1'b0;
      endcase
      word = (in_class == 4'd0) ? {op, in_rs, in_rt, in_rd, 5'b00000, in_funct} :
             (in_class == 4'd9) ? {op, in_target} : {op, in_rs, in_rt, in_imm};
   end

   always_comb begin
      take   = in_valid && rdy_q;
      push   = take && legal;
      pop    = (cnt_q != 2'd0) && out_ready;
      slot   = cnt_q - 2'(pop);
      cnt_d  = cnt_q + 2'(push) - 2'(pop);
      e0_d   = pop ? e1_q : e0_q;
      e1_d   = e1_q;
      addr_d = pop ? addr_q + 32'd4 : addr_q;
      emit_d = pop ? emit_q + 32'd1 : emit_q;
      acc_d  = push ? acc_q + 32'd1 : acc_q;
      full_d = full_q || (emit_d == 32'(MEM_WORDS));
      ill_d  = ill_q || (take && !legal);
      icnt_d = (take && !legal && icnt_q != 8'hFF) ? icnt_q + 8'd1 : icnt_q;
      if (push && slot == 2'd0) e0_d = word;
      if (push && slot != 2'd0) e1_d = word;
      if (clear) begin
         cnt_d  = 2'd0;
         e0_d   = 32'd0;
         e1_d   = 32'd0;
         addr_d = BASE_ADDR;
         emit_d = 32'd0;
         acc_d  = 32'd0;
         full_d = 1'b0;
         ill_d  = 1'b0;
         icnt_d = 8'd0;
      end
      // ready is registered, so it must already account for this cycle's push
      rdy_d = !full_d && (cnt_d < 2'd2) && (acc_d < 32'(MEM_WORDS));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         e0_q   <= 32'd0;
         e1_q   <= 32'd0;
         addr_q <= BASE_ADDR;
         emit_q <= 32'd0;
         acc_q  <= 32'd0;
         full_q <= 1'b0;
         ill_q  <= 1'b0;
         icnt_q <= 8'd0;
         rdy_q  <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         e0_q   <= e0_d;
         e1_q   <= e1_d;
         addr_q <= addr_d;
         emit_q <= emit_d;
         acc_q  <= acc_d;
         full_q <= full_d;
         ill_q  <= ill_d;
         icnt_q <= icnt_d;
         rdy_q  <= rdy_d;
      end
   end

   assign in_ready      = rdy_q;
   assign out_valid     = cnt_q != 2'd0;
   assign out_instr     = e0_q;
   assign out_addr      = addr_q;
   assign full          = full_q;
   assign illegal       = ill_q;
   assign illegal_count = icnt_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed stimulus feeds a scoreboard queue; a negedge
// monitor pops and compares every emitted word and checks hold-while-stalled.
module tb_mips_instr_encoder;
   logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, full, illegal;
   logic [3:0]  in_class = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [5:0]  in_funct = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic [31:0] out_instr, out_addr;
   logic [7:0]  illegal_count;

   int          n_pass = 0, n_tot = 0, xfers = 0, cyc = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_addr = 32'd0, hold_i, hold_a;
   logic        stall = 1'b0;

   mips_instr_encoder #(.BASE_ADDR(32'h0), .MEM_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
      .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .full(full), .illegal(illegal),
      .illegal_count(illegal_count));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (stall && out_valid) begin
         chk("hold_instr", out_instr, hold_i);
         chk("hold_addr", out_addr, hold_a);
      end
      if (out_valid === 1'b1 && out_ready) begin
         xfers++;
         if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_word: got %h at %h required none", out_instr, out_addr);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("instr", out_instr, e[63:32]);
            chk("addr", out_addr, e[31:0]);
         end
      end
      stall  = (out_valid === 1'b1) && !out_ready;
      hold_i = out_instr;
      hold_a = out_addr;
   end

   // holds the bundle until accepted; legal words go into the scoreboard
   task automatic send(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                       input logic [25:0] tg, input bit lg, input logic [31:0] w);
      logic r;
      int n = 0;
      in_valid = 1'b1; in_class = c; in_rs = rs; in_rt = rt; in_rd = rd;
      in_funct = f; in_imm = imm; in_target = tg;
      do begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 50);
      in_valid = 1'b0;
      if (!r) begin
         n_tot++;
         $display("FAIL accept_timeout: got in_ready=0 required 1");
      end else if (lg) begin
         exp_q.push_back({w, exp_addr});
         exp_addr += 32'd4;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_tot++;
         $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_q.delete();
      exp_addr = 32'd0;
   endtask

   task automatic chk_reset_vals(input string tag);
      @(negedge clk);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'd0);
      chk({tag, "_out_addr"}, out_addr, 32'd0);
      chk({tag, "_full"}, {31'd0, full}, 32'd0);
      chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
      chk({tag, "_icount"}, {24'd0, illegal_count}, 32'd0);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0, c0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      send(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1, 32'h00221820);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      drain();
      do_clear();

      t0 = xfers; c0 = cyc;
      send(4'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0008, 26'h0, 1, 32'h8C220008);
      send(4'd2, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0, 1, 32'hAC220004);
      send(4'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1, 32'h1022FFFF);
      send(4'd9, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1, 32'h08000010);
      chk("stream_cycles", 32'(cyc - c0), 32'd4);
      @(posedge clk);
      #1;
      chk("stream_xfers", 32'(xfers - t0), 32'd4);
      chk("stream_full", {31'd0, full}, 32'd1);
      do_clear();
      chk("clear_full", {31'd0, full}, 32'd0);
      chk("clear_addr", out_addr, 32'd0);

      out_ready = 1'b0;
      send(4'd4, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0010, 26'h0, 1, 32'h20640010);
      send(4'd5, 5'd5, 5'd6, 5'd0, 6'h0, 16'h00FF, 26'h0, 1, 32'h30A600FF);
      fork
         send(4'd6, 5'd7, 5'd8, 5'd0, 6'h0, 16'h1234, 26'h0, 1, 32'h34E81234);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_xfers", 32'(xfers - t0), 32'd7);
      do_clear();

      send(4'd12, 5'd1, 5'd1, 5'd1, 6'h20, 16'h0, 26'h0, 0, 32'h0);
      send(4'd0, 5'd1, 5'd2, 5'd3, 6'h00, 16'h0, 26'h0, 0, 32'h0);
      send(4'd4, 5'd0, 5'd1, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1, 32'h2001FFFF);
      send(4'd7, 5'd2, 5'd3, 5'd0, 6'h0, 16'h00AA, 26'h0, 1, 32'h384300AA);
      send(4'd8, 5'd1, 5'd1, 5'd0, 6'h0, 16'h8000, 26'h0, 1, 32'h28218000);
      drain();
      chk("illegal_flag", {31'd0, illegal}, 32'd1);
      chk("illegal_count", {24'd0, illegal_count}, 32'd2);
      for (int i = 0; i < 260; i++) send(4'd15, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 0, 32'h0);
      chk("illegal_sat", {24'd0, illegal_count}, 32'd255);
      do_clear();
      chk("clear_icount", {24'd0, illegal_count}, 32'd0);
      chk("clear_illegal", {31'd0, illegal}, 32'd0);

      t0 = xfers;
      send(4'd0, 5'd4, 5'd5, 5'd6, 6'h24, 16'h0, 26'h0, 1, 32'h00853024);
      send(4'd0, 5'd4, 5'd5, 5'd6, 6'h25, 16'h0, 26'h0, 1, 32'h00853025);
      send(4'd0, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h0, 26'h0, 1, 32'h0085302A);
      send(4'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 1, 32'h34000001);
      in_valid = 1'b1; in_class = 4'd4;
      repeat (4) begin
         @(negedge clk);
         chk("cap_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("cap_xfers", 32'(xfers - t0), 32'd4);
      chk("cap_full", {31'd0, full}, 32'd1);
      do_clear();
      chk("reclear_full", {31'd0, full}, 32'd0);
      chk("reclear_in_ready", {31'd0, in_ready}, 32'd1);
      send(4'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'h0, 26'h0, 1, 32'h00221822);
      drain();

      do_clear();
      out_ready = 1'b0;
      send(4'd13, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 0, 32'h0);
      send(4'd4, 5'd1, 5'd1, 5'd0, 6'h0, 16'h0001, 26'h0, 1, 32'h20210001);
      send(4'd4, 5'd2, 5'd2, 5'd0, 6'h0, 16'h0002, 26'h0, 1, 32'h20420002);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      exp_addr = 32'd0;
      chk_reset_vals("midrst");
      rst_n = 1'b1;
      send(4'd4, 5'd1, 5'd1, 5'd0, 6'h0, 16'h0001, 26'h0, 1, 32'h20210001);
      send(4'd4, 5'd2, 5'd2, 5'd0, 6'h0, 16'h0002, 26'h0, 1, 32'h20420002);
      rst_n = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_q.delete();
      exp_addr = 32'd0;
      chk_reset_vals("rstclr");
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(4'd1, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0010, 26'h0, 1, 32'h8C640010);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
